id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode stage and ID/EX pipeline register of the 5-stage pipeline.
- Takes the IF/ID instruction and drives the register-bank read addresses (rs1/rs2).
- Captures the returned operands, applying write-back bypass, and decodes immediates and control.
- Detects load-use hazards, stalls upstream and inserts bubbles; flush squashes the stage on a taken branch or jump.

Parameters:
- XLEN, 32, datapath width of PC, instruction, operands and immediate.
- NREG_BITS, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_instr  in  XLEN  instruction word (RV32I encoding)
- in_pc  in  XLEN  PC of in_instr
- flush  in  1  squash the instruction entering ID/EX this cycle
- rs1  out  NREG_BITS  reg-bank read address 1 = in_instr[19:15]
- rs2  out  NREG_BITS  reg-bank read address 2 = in_instr[24:20]
- r1  in  XLEN  reg-bank data for rs1, valid before the rising edge
- r2  in  XLEN  reg-bank data for rs2, valid before the rising edge
- wb_en  in  1  write-back stage writes this cycle
- wb_rd  in  NREG_BITS  write-back destination
- wb_data  in  XLEN  write-back data
- stall  out  1  hold PC and IF/ID (combinational)
- out_valid  out  1  ID/EX entry valid
- out_pc, out_op1, out_op2, out_imm  out  XLEN  registered PC, operands, sign-extended immediate
- out_rd  out  NREG_BITS  destination register
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7b5  out  1  instr[30]
- out_reg_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal  out  1 each  control bits

Behaviour:
- Reset (async, rst_n low): every registered output is 0; out_valid = 0. Release is synchronous to the next clk edge.
- rs1 and rs2 are combinational slices of in_instr, independent of in_valid.
- Opcode classes:
  - LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - Any other opcode: out_illegal = 1, out_reg_we = 0, no stall generated.
- Register usage:
  - uses_rs1: all legal opcodes except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH.
  - reg_we: all legal opcodes except STORE and BRANCH, and only when rd != 0.
- Immediates (sign-extended from instr[31]):
  - I-type: LOAD, OP-IMM, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit 0 = 0.
  - U-type: LUI, AUIPC; imm = instr[31:12] << 12.
  - J-type: JAL, bit 0 = 0.
  - OP: imm = 0.
- Operand select, per operand:
  - Address 0 forces 0.
  - Otherwise, if wb_en and wb_rd == address, use wb_data.
  - Otherwise use r1 / r2.
- Load-use stall: stall = in_valid & out_valid & out_is_load & out_rd != 0 & ((uses_rs1 & out_rd == rs1) | (uses_rs2 & out_rd == rs2)). Raised in the cycle the consumer sits in IF/ID.
- Clock-edge update, in priority order:
  1. flush = 1: out_valid <= 0. Flush overrides stall; stall output is still driven combinationally.
  2. stall = 1: out_valid <= 0 (bubble). Other fields may update; they are don't-care while out_valid = 0.
  3. Otherwise: out_valid <= in_valid and all fields load from decode.
- Stall lasts exactly one cycle per load-use pair:
  - After the bubble, out_valid = 0, so stall drops.
  - The consumer is then re-decoded; its operand comes from downstream forwarding or from WB bypass.
- Latency: 1 cycle, in_instr to out_* registered.
- With out_valid = 0, control bits still reflect the last decode; consumers must qualify every bit with out_valid.
- Reset during a stall: all state clears, stall drops combinationally because out_valid = 0.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stalls (32) and perf_flushes (32).
  - perf_stalls increments on every edge where stall = 1 and flush = 0.
  - perf_flushes increments on every edge where flush = 1 and in_valid = 1.
  - Both counters wrap at 2^32 and clear on rst_n.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles mid-stream → out_valid = 0 and all outputs 0 asynchronously. First valid instr after release appears 1 cycle later.
- Decode: addi x5,x1,-4 (0xFFC08293), r1 = 10 → out_op1 = 10, out_imm = 0xFFFFFFFC, out_rd = 5, out_reg_we = 1, out_valid = 1 next cycle.
- WB bypass: add x3,x1,x2 while wb_en = 1, wb_rd = 2, wb_data = 0x55, r2 = 0x11 → out_op2 = 0x55. Repeat with wb_rd = 0 → out_op2 = 0x11.
- Load-use: lw x6,0(x1) followed by add x7,x6,x6 → stall = 1 for exactly 1 cycle, one bubble (out_valid = 0), then add issues with out_rd = 7.
- Flush vs stall: assert flush in the stall cycle → out_valid = 0 next cycle; with ID_PERF_CNT_EN, perf_flushes += 1 and perf_stalls unchanged.
- x0 / illegal: sw x0,4(x0) → out_op2 = 0, out_reg_we = 0, out_imm = 4. Opcode 0x7F → out_illegal = 1, stall = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode stage and ID/EX pipeline register.
// Drives the register-bank read addresses and applies write-back bypass to the
// returned operands. Detects load-use hazards, which stall upstream and insert
// a bubble. Flush squashes the instruction entering ID/EX.
// Optional build macro ID_PERF_CNT_EN adds the stall and flush event counters
// perf_stalls and perf_flushes.
module id_ex_stage #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [XLEN-1:0]      in_instr,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 flush,
    output logic [NREG_BITS-1:0] rs1,
    output logic [NREG_BITS-1:0] rs2,
    input  logic [XLEN-1:0]      r1,
    input  logic [XLEN-1:0]      r2,
    input  logic                 wb_en,
    input  logic [NREG_BITS-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 stall,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [XLEN-1:0]      out_imm,
    output logic [NREG_BITS-1:0] out_rd,
    output logic [6:0]           out_opcode,
    output logic [2:0]           out_funct3,
    output logic                 out_funct7b5,
    output logic                 out_reg_we,
    output logic                 out_is_load,
    output logic                 out_is_store,
    output logic                 out_is_branch,
    output logic                 out_is_jump,
    output logic                 out_illegal
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stalls,
    output logic [31:0]          perf_flushes
`endif
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic signed [XLEN-1:0] imm_i(input logic [XLEN-1:0] ins);
        imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_s(input logic [XLEN-1:0] ins);
        imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_b(input logic [XLEN-1:0] ins);
        imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic signed [XLEN-1:0] imm_u(input logic [XLEN-1:0] ins);
        imm_u = XLEN'($signed({ins[31:12], 12'b0}));
    endfunction

    function automatic logic signed [XLEN-1:0] imm_j(input logic [XLEN-1:0] ins);
        imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    // x0 reads as zero; a same-cycle write-back to the read address wins over the bank
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [NREG_BITS-1:0] addr,
        input logic [XLEN-1:0]      rdata,
        input logic                 byp_en,
        input logic [NREG_BITS-1:0] byp_rd,
        input logic [XLEN-1:0]      byp_data
    );
        if (addr == '0)
            sel_operand = '0;
        else if (byp_en && (byp_rd == addr))
            sel_operand = byp_data;
        else
            sel_operand = rdata;
    endfunction

    logic [6:0]             opcode_p0;
    logic [NREG_BITS-1:0]   rd_p0;
    logic                   legal_p0;
    logic                   uses_rs1_p0;
    logic                   uses_rs2_p0;
    logic                   is_load_p0;
    logic                   is_store_p0;
    logic                   is_branch_p0;
    logic                   is_jump_p0;
    logic                   reg_we_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic [XLEN-1:0]        op1_p0;
    logic [XLEN-1:0]        op2_p0;
    logic                   load_p0;

    assign opcode_p0 = in_instr[6:0];
    assign rd_p0     = in_instr[11:7];
    assign rs1       = in_instr[19:15];
    assign rs2       = in_instr[24:20];
    assign op1_p0    = sel_operand(rs1, r1, wb_en, wb_rd, wb_data);
    assign op2_p0    = sel_operand(rs2, r2, wb_en, wb_rd, wb_data);
    assign reg_we_p0 = legal_p0 & ~is_store_p0 & ~is_branch_p0 & (rd_p0 != '0);

    // Opcode class decode: register usage, control bits and immediate format
    always_comb begin
        legal_p0     = 1'b1;
        uses_rs1_p0  = 1'b1;
        uses_rs2_p0  = 1'b0;
        is_load_p0   = 1'b0;
        is_store_p0  = 1'b0;
        is_branch_p0 = 1'b0;
        is_jump_p0   = 1'b0;
        imm_p0       = '0;
        case (opcode_p0)
            OPC_LOAD: begin
                is_load_p0 = 1'b1;
                imm_p0     = imm_i(in_instr);
            end
            OPC_STORE: begin
                is_store_p0 = 1'b1;
                uses_rs2_p0 = 1'b1;
                imm_p0      = imm_s(in_instr);
            end
            OPC_OPIMM: imm_p0 = imm_i(in_instr);
            OPC_OP:    uses_rs2_p0 = 1'b1;
            OPC_BRANCH: begin
                is_branch_p0 = 1'b1;
                uses_rs2_p0  = 1'b1;
                imm_p0       = imm_b(in_instr);
            end
            OPC_LUI, OPC_AUIPC: begin
                uses_rs1_p0 = 1'b0;
                imm_p0      = imm_u(in_instr);
            end
            OPC_JAL: begin
                is_jump_p0  = 1'b1;
                uses_rs1_p0 = 1'b0;
                imm_p0      = imm_j(in_instr);
            end
            OPC_JALR: begin
                is_jump_p0 = 1'b1;
                imm_p0     = imm_i(in_instr);
            end
            default: begin
                legal_p0    = 1'b0;
                uses_rs1_p0 = 1'b0;
            end
        endcase
    end

    // Load-use hazard: the valid load in ID/EX writes a register this instruction reads
    always_comb begin
        stall = in_valid & out_valid & out_is_load & (out_rd != '0) &
                ((uses_rs1_p0 & (out_rd == rs1)) | (uses_rs2_p0 & (out_rd == rs2)));
    end

    assign load_p0 = ~flush & ~stall;

    // ---- ID -> EX boundary: flush beats stall, stall inserts a bubble ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_op1       <= '0;
            out_op2       <= '0;
            out_imm       <= '0;
            out_rd        <= '0;
            out_opcode    <= '0;
            out_funct3    <= '0;
            out_funct7b5  <= 1'b0;
            out_reg_we    <= 1'b0;
            out_is_load   <= 1'b0;
            out_is_store  <= 1'b0;
            out_is_branch <= 1'b0;
            out_is_jump   <= 1'b0;
            out_illegal   <= 1'b0;
        end else begin
            out_valid <= in_valid & load_p0;
            if (load_p0) begin
                out_pc        <= in_pc;
                out_op1       <= op1_p0;
                out_op2       <= op2_p0;
                out_imm       <= imm_p0;
                out_rd        <= rd_p0;
                out_opcode    <= opcode_p0;
                out_funct3    <= in_instr[14:12];
                out_funct7b5  <= in_instr[30];
                out_reg_we    <= reg_we_p0;
                out_is_load   <= is_load_p0;
                out_is_store  <= is_store_p0;
                out_is_branch <= is_branch_p0;
                out_is_jump   <= is_jump_p0;
                out_illegal   <= ~legal_p0;
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    // Event counters: effective stalls and squashed valid instructions, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (stall && !flush)
                perf_stalls <= perf_stalls + 32'd1;
            if (flush && in_valid)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, randomized stream against a reference
// model, and hand sequences for load-use, flush-vs-stall and mid-stream reset.
`timescale 1ns/1ps
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic [31:0] r1, r2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc, out_op1, out_op2, out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5, out_reg_we, out_is_load, out_is_store;
    logic        out_is_branch, out_is_jump, out_illegal;
`ifdef ID_PERF_CNT_EN
    logic [31:0] perf_stalls, perf_flushes;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .NREG_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .rs1(rs1), .rs2(rs2), .r1(r1), .r2(r2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_op1(out_op1),
        .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7b5(out_funct7b5), .out_reg_we(out_reg_we),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
        .out_illegal(out_illegal)
`ifdef ID_PERF_CNT_EN
        , .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, op1, op2, imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5, reg_we, is_load, is_store, is_branch, is_jump, illegal;
    } exp_t;

    exp_t        m;
    logic [31:0] m_pstall, m_pflush;

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    endfunction

    function automatic bit uses1(input logic [6:0] op);
        return is_legal(op) && !(op inside {7'h37, 7'h17, 7'h6F});
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    // immediate value computed arithmetically from the field weights
    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        int v;
        v = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: v = $signed(ins) >>> 20;
            7'h23: v = (($signed(ins) >>> 20) & -32) + int'(ins[11:7]);
            7'h63: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                       + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            7'h37, 7'h17: v = int'(ins & 32'hFFFFF000);
            7'h6F: v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                       + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_opnd(input logic [4:0] a, input logic [31:0] bank);
        if (a == 0) return 32'd0;
        if (wb_en && wb_rd == a) return wb_data;
        return bank;
    endfunction

    function automatic bit model_stall();
        logic [6:0] op;
        op = in_instr[6:0];
        return in_valid && m.valid && m.is_load && m.rd != 0 &&
               ((uses1(op) && m.rd == in_instr[19:15]) || (uses2(op) && m.rd == in_instr[24:20]));
    endfunction

    function automatic exp_t model_decode();
        exp_t d;
        logic [6:0] op;
        op          = in_instr[6:0];
        d.valid     = in_valid;
        d.pc        = in_pc;
        d.op1       = model_opnd(in_instr[19:15], r1);
        d.op2       = model_opnd(in_instr[24:20], r2);
        d.imm       = model_imm(in_instr);
        d.rd        = in_instr[11:7];
        d.opc       = op;
        d.f3        = in_instr[14:12];
        d.f7b5      = in_instr[30];
        d.illegal   = !is_legal(op);
        d.is_load   = (op == 7'h03);
        d.is_store  = (op == 7'h23);
        d.is_branch = (op == 7'h63);
        d.is_jump   = (op == 7'h6F) || (op == 7'h67);
        d.reg_we    = is_legal(op) && !d.is_store && !d.is_branch && d.rd != 0;
        return d;
    endfunction

    // one clock edge: DUT and model both advance on the same inputs
    task automatic tick();
        bit   s;
        exp_t d;
        s = model_stall();
        d = model_decode();
        @(posedge clk);
        if (s && !flush) m_pstall++;
        if (flush && in_valid) m_pflush++;
        if (flush || s) m.valid = 1'b0;
        else m = d;
        #1;
    endtask

    task automatic check_comb(input string tag);
        chk({tag, ".stall"}, stall, model_stall());
        chk({tag, ".rs1"}, rs1, in_instr[19:15]);
        chk({tag, ".rs2"}, rs2, in_instr[24:20]);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".valid"}, out_valid, m.valid);
        if (m.valid) begin
            chk({tag, ".pc"}, out_pc, m.pc);
            chk({tag, ".op1"}, out_op1, m.op1);
            chk({tag, ".op2"}, out_op2, m.op2);
            if (!m.illegal) chk({tag, ".imm"}, out_imm, m.imm);
            chk({tag, ".rd"}, out_rd, m.rd);
            chk({tag, ".ctl"},
                {out_opcode, out_funct3, out_funct7b5, out_reg_we, out_is_load,
                 out_is_store, out_is_branch, out_is_jump, out_illegal},
                {m.opc, m.f3, m.f7b5, m.reg_we, m.is_load, m.is_store,
                 m.is_branch, m.is_jump, m.illegal});
        end
`ifdef ID_PERF_CNT_EN
        chk({tag, ".pstall"}, perf_stalls, m_pstall);
        chk({tag, ".pflush"}, perf_flushes, m_pflush);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, out_valid, 1'b0);
        chk({tag, ".data"}, out_pc | out_op1 | out_op2 | out_imm, 32'd0);
        chk({tag, ".ctl"},
            {out_rd, out_opcode, out_funct3, out_funct7b5, out_reg_we, out_is_load,
             out_is_store, out_is_branch, out_is_jump, out_illegal}, 32'd0);
        chk({tag, ".stall"}, stall, 1'b0);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] instr, r1, r2;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] e_op1, e_op2, e_imm;
        logic [4:0]  e_rd;
        logic        e_we, e_ill, chk_imm;
    } vec_t;

    vec_t tbl[5];

    localparam logic [31:0] I_LW   = 32'h0000A303;  // lw  x6,0(x1)
    localparam logic [31:0] I_ADD6 = 32'h006303B3;  // add x7,x6,x6
    localparam logic [31:0] I_ADDI = 32'hFFC08293;  // addi x5,x1,-4

    initial begin
        logic [6:0] ops[13];
        logic [31:0] ins;
        logic [31:0] ps0, pf0;

        tbl[0] = '{I_ADDI,       32'd10, 32'h99, 1'b0, 5'd0, 32'h0,
                   32'd10, 32'h99, 32'hFFFFFFFC, 5'd5, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h002081B3, 32'd7,  32'h11, 1'b1, 5'd2, 32'h55,
                   32'd7,  32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h002081B3, 32'd7,  32'h11, 1'b1, 5'd0, 32'h55,
                   32'd7,  32'h11, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{32'h00002223, 32'h33, 32'hAA, 1'b0, 5'd0, 32'h77,
                   32'd0,  32'd0,  32'd4, 5'd4, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'h0000007F, 32'h5,  32'h6,  1'b0, 5'd0, 32'h0,
                   32'd0,  32'd0,  32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        ops = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67,
                7'h03, 7'h03, 7'h7F, 7'h00};

        // reset
        rst_n = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        r1 = '0; r2 = '0;
        drive(1'b0, 32'h0, 32'h0);
        m = '0; m_pstall = '0; m_pflush = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, tbl[i].instr, 32'h100 + 32'(i * 4));
            r1 = tbl[i].r1; r2 = tbl[i].r2;
            wb_en = tbl[i].wb_en; wb_rd = tbl[i].wb_rd; wb_data = tbl[i].wb_data;
            #1;
            chk($sformatf("v%0d.stall", i), stall, 1'b0);
            tick();
            chk($sformatf("v%0d.valid", i), out_valid, 1'b1);
            chk($sformatf("v%0d.pc", i), out_pc, 32'h100 + 32'(i * 4));
            chk($sformatf("v%0d.op1", i), out_op1, tbl[i].e_op1);
            chk($sformatf("v%0d.op2", i), out_op2, tbl[i].e_op2);
            if (tbl[i].chk_imm) chk($sformatf("v%0d.imm", i), out_imm, tbl[i].e_imm);
            chk($sformatf("v%0d.rd", i), out_rd, tbl[i].e_rd);
            chk($sformatf("v%0d.we", i), out_reg_we, tbl[i].e_we);
            chk($sformatf("v%0d.ill", i), out_illegal, tbl[i].e_ill);
        end

        // randomized stream against the model
        for (int c = 0; c < 400; c++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 12)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive(($urandom_range(0, 9) < 8), ins, $urandom);
            flush   = ($urandom_range(0, 9) == 0);
            r1      = $urandom;
            r2      = $urandom;
            wb_en   = $urandom_range(0, 1);
            wb_rd   = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            #1;
            check_comb($sformatf("rnd%0d", c));
            tick();
            check_regs($sformatf("rnd%0d", c));
        end

        // load-use: exactly one stall cycle and one bubble
        flush = 1'b0; wb_en = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b1, I_LW, 32'h200);
        #1;
        tick();
        chk("lu.load", out_is_load, 1'b1);
        drive(1'b1, I_ADD6, 32'h204);
        #1;
        chk("lu.stall1", stall, 1'b1);
        tick();
        chk("lu.bubble", out_valid, 1'b0);
        chk("lu.stall2", stall, 1'b0);
        tick();
        chk("lu.issue", out_valid, 1'b1);
        chk("lu.rd", out_rd, 5'd7);
        check_regs("lu");

        // flush in the stall cycle
        drive(1'b1, I_LW, 32'h300);
        #1;
        tick();
        drive(1'b1, I_ADD6, 32'h304);
        flush = 1'b1;
        #1;
        chk("fs.stall", stall, 1'b1);
`ifdef ID_PERF_CNT_EN
        ps0 = perf_stalls; pf0 = perf_flushes;
`else
        ps0 = 32'd0; pf0 = 32'd0;
`endif
        tick();
        chk("fs.valid", out_valid, 1'b0);
`ifdef ID_PERF_CNT_EN
        chk("fs.pflush", perf_flushes, pf0 + 32'd1);
        chk("fs.pstall", perf_stalls, ps0);
`endif
        flush = 1'b0;
        check_regs("fs");

        // reset asserted mid-stream while a stall is pending
        drive(1'b1, I_LW, 32'h400);
        #1;
        tick();
        drive(1'b1, I_ADD6, 32'h404);
        #1;
        chk("rs.stall", stall, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rs.async");
        m = '0; m_pstall = '0; m_pflush = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rs.hold");
        r1 = 32'd10;
        drive(1'b1, I_ADDI, 32'h500);
        rst_n = 1'b1;
        #1;
        tick();
        chk("rs.first", out_valid, 1'b1);
        chk("rs.op1", out_op1, 32'd10);
        check_regs("rs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
